// File: rtl/wdg_pkg.sv
// rtl/wdg_pkg.sv - shared watchdog state encoding and timeout clamp helper
package wdg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WARN,
    ST_TRIP
  } wdg_state_t;

  // Fixed 64-bit width so any CNT_W up to 64 can share one helper.
  function automatic logic [63:0] clamp_timeout(input logic [63:0] value,
                                                input logic [63:0] floor_value);
    return (value < floor_value) ? floor_value : value;
  endfunction

endpackage

// File: rtl/wdg_channel.sv
// rtl/wdg_channel.sv - one watchdog channel: FSM, counter, pending and active timeout
module wdg_channel
  import wdg_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_DEF = 50_000_000,
  parameter int WARN_MARGIN = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             heartbeat,
  input  logic             clear,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_value,
  output logic             warning,
  output logic             triggered,
  output logic             trip_enter
);

  wdg_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] pend, active;
  logic [CNT_W-1:0] warn_at, last_at;
  logic             reload;

  // Comparing the pre-edge count makes warning rise timeout-WARN_MARGIN edges
  // after a clear and the trip land exactly timeout edges after it.
  assign warn_at = active - CNT_W'(WARN_MARGIN + 1);
  assign last_at = active - CNT_W'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    reload   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        reload = 1'b1;
        if (enable) state_nx = ST_RUN;
      end
      ST_RUN, ST_WARN: begin
        if (!enable) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          reload   = 1'b1;
        end else if (heartbeat) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
          reload   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          if (state == ST_RUN && cnt == warn_at) state_nx = ST_WARN;
          if (state == ST_WARN && cnt == last_at) begin
            state_nx = ST_TRIP;
            cnt_nx   = cnt;
          end
        end
      end
      ST_TRIP: begin
        if (clear) begin
          state_nx = enable ? ST_RUN : ST_IDLE;
          cnt_nx   = '0;
          reload   = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign trip_enter = (state_nx == ST_TRIP) && (state != ST_TRIP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pend      <= CNT_W'(TIMEOUT_DEF);
      active    <= CNT_W'(TIMEOUT_DEF);
      warning   <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      if (cfg_wr) pend <= cfg_value;
      if (reload) active <= pend;
      warning   <= (state_nx == ST_WARN);
      triggered <= (state_nx == ST_TRIP);
    end
  end

endmodule

// File: rtl/multi_watchdog.sv
// rtl/multi_watchdog.sv - N-channel watchdog with config decode, reset pulse stretcher, trip counter
module multi_watchdog
  import wdg_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_DEF = 50_000_000,
  parameter int WARN_MARGIN = 10_000_000,
  parameter int RST_PULSE   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_CH-1:0]                        enable,
  input  logic [N_CH-1:0]                        heartbeat,
  input  logic [N_CH-1:0]                        clear,
  input  logic                                   cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                       cfg_timeout,
  output logic [N_CH-1:0]                        warning,
  output logic [N_CH-1:0]                        triggered,
  output logic                                   force_reset,
  output logic [7:0]                             trip_count
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PULSE_W = $clog2(RST_PULSE + 1);

  logic [CNT_W-1:0]   cfg_clamped;
  logic [N_CH-1:0]    cfg_wr;
  logic [N_CH-1:0]    trip_enter;
  logic [4:0]         n_enter;
  logic [8:0]         count_sum;
  logic [PULSE_W-1:0] pulse_cnt;

  assign cfg_clamped = CNT_W'(clamp_timeout(64'(cfg_timeout), 64'(WARN_MARGIN + 2)));

  // Selects beyond N_CH match no channel, so such writes are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign cfg_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    wdg_channel #(
      .CNT_W       (CNT_W),
      .TIMEOUT_DEF (TIMEOUT_DEF),
      .WARN_MARGIN (WARN_MARGIN)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable[i]),
      .heartbeat  (heartbeat[i]),
      .clear      (clear[i]),
      .cfg_wr     (cfg_wr[i]),
      .cfg_value  (cfg_clamped),
      .warning    (warning[i]),
      .triggered  (triggered[i]),
      .trip_enter (trip_enter[i])
    );
  end

  always_comb begin
    n_enter = '0;
    for (int i = 0; i < N_CH; i++) n_enter = n_enter + 5'(trip_enter[i]);
  end

  assign count_sum   = {1'b0, trip_count} + {4'b0, n_enter};
  assign force_reset = (pulse_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt  <= '0;
      trip_count <= '0;
    end else begin
      if (|trip_enter) pulse_cnt <= PULSE_W'(RST_PULSE);
      else if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PULSE_W'(1);
      trip_count <= (count_sum > 9'd255) ? 8'hFF : count_sum[7:0];
    end
  end

endmodule

// File: tb/tb_multi_watchdog.sv
// tb/tb_multi_watchdog.sv - self-checking bench for multi_watchdog
module tb_multi_watchdog;

  localparam int N_CH = 2;
  localparam int CNT_W = 16;
  localparam int TDEF = 8;
  localparam int WM = 3;
  localparam int RPULSE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_CH-1:0]   enable = '0, heartbeat = '0, clear = '0;
  logic              cfg_we = 1'b0;
  logic [0:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_timeout = '0;
  logic [N_CH-1:0]   warning, triggered;
  logic              force_reset;
  logic [7:0]        trip_count;

  int checks = 0;
  int errors = 0;

  multi_watchdog #(
    .N_CH(N_CH), .CNT_W(CNT_W), .TIMEOUT_DEF(TDEF), .WARN_MARGIN(WM), .RST_PULSE(RPULSE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .heartbeat(heartbeat), .clear(clear),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_timeout(cfg_timeout),
    .warning(warning), .triggered(triggered), .force_reset(force_reset),
    .trip_count(trip_count)
  );

  always #5 clk = ~clk;

  // Reference: per channel a mode (0 off, 1 armed, 2 tripped) and cycles since last clear.
  int m_mode[N_CH], m_elapsed[N_CH], m_active[N_CH], m_pend[N_CH];
  int m_pulse, m_count;

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = 0; m_elapsed[c] = 0; m_active[c] = TDEF; m_pend[c] = TDEF;
    end
    m_pulse = 0; m_count = 0;
  endfunction

  function automatic void model_step();
    int entering = 0;
    for (int c = 0; c < N_CH; c++) begin
      if (m_mode[c] == 0) begin
        m_active[c] = m_pend[c];
        if (enable[c]) begin m_mode[c] = 1; m_elapsed[c] = 0; end
      end else if (m_mode[c] == 1) begin
        if (!enable[c]) begin
          m_mode[c] = 0; m_elapsed[c] = 0; m_active[c] = m_pend[c];
        end else if (heartbeat[c]) begin
          m_elapsed[c] = 0; m_active[c] = m_pend[c];
        end else begin
          m_elapsed[c]++;
          if (m_elapsed[c] == m_active[c]) begin m_mode[c] = 2; entering++; end
        end
      end else if (clear[c]) begin
        m_elapsed[c] = 0; m_active[c] = m_pend[c]; m_mode[c] = enable[c] ? 1 : 0;
      end
    end
    if (cfg_we && int'(cfg_ch) < N_CH)
      m_pend[cfg_ch] = (int'(cfg_timeout) < WM + 2) ? WM + 2 : int'(cfg_timeout);
    if (entering > 0) m_pulse = RPULSE;
    else if (m_pulse > 0) m_pulse--;
    m_count = (m_count + entering > 255) ? 255 : m_count + entering;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [N_CH-1:0] w, t;
    for (int c = 0; c < N_CH; c++) begin
      w[c] = (m_mode[c] == 1) && (m_elapsed[c] >= m_active[c] - WM);
      t[c] = (m_mode[c] == 2);
    end
    chk("model_warning", 32'(warning), 32'(w));
    chk("model_triggered", 32'(triggered), 32'(t));
    chk("model_force_reset", 32'(force_reset), 32'(m_pulse > 0));
    chk("model_trip_count", 32'(trip_count), 32'(m_count));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    enable = '0; heartbeat = '0; clear = '0; cfg_we = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] en, hb, clr;
    logic [1:0] w, t;
    logic       f;
    int         c;
  } vec_t;

  function automatic vec_t mk(logic [1:0] en, logic [1:0] hb, logic [1:0] clr,
                              logic [1:0] w, logic [1:0] t, logic f, int c);
    vec_t v;
    v.en = en; v.hb = hb; v.clr = clr; v.w = w; v.t = t; v.f = f; v.c = c;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    int n, wcnt, tcnt, fcnt;

    // Single-channel timeout with no heartbeat: row k is the state after edge k.
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0);
    tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0);
    tbl[2]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0);
    tbl[3]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0);
    tbl[5]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0);
    tbl[6]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0);
    tbl[7]  = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0);
    tbl[8]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1);
    tbl[9]  = mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1);
    tbl[10] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1);
    tbl[11] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1);
    tbl[12] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1);
    tbl[13] = mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1);
    tbl[14] = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1);

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_warning", 32'(warning), 0);
    chk("reset_triggered", 32'(triggered), 0);
    chk("reset_force", 32'(force_reset), 0);
    chk("reset_count", 32'(trip_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en; heartbeat = tbl[i].hb; clear = tbl[i].clr;
      cycle();
      chk($sformatf("tbl%0d_warning", i), 32'(warning), 32'(tbl[i].w));
      chk($sformatf("tbl%0d_triggered", i), 32'(triggered), 32'(tbl[i].t));
      chk($sformatf("tbl%0d_force", i), 32'(force_reset), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_count", i), 32'(trip_count), 32'(tbl[i].c));
    end

    // Heartbeat every 6 cycles: warning blips, never trips.
    do_reset();
    enable = 2'b01; wcnt = 0; tcnt = 0; fcnt = 0;
    for (int i = 0; i < 30; i++) begin
      heartbeat = (i > 0 && i % 6 == 0) ? 2'b01 : 2'b00;
      cycle();
      wcnt += int'(warning[0]); tcnt += int'(triggered[0]); fcnt += int'(force_reset);
    end
    chk("hb6_warn_cycles", wcnt, 5);
    chk("hb6_trip_cycles", tcnt, 0);
    chk("hb6_force_cycles", fcnt, 0);
    heartbeat = '0;

    // Heartbeat exactly on the terminal-count edge wins and restarts the count.
    do_reset();
    enable = 2'b01;
    for (int i = 0; i < 8; i++) cycle();
    heartbeat = 2'b01;
    cycle();
    chk("coincide_triggered", 32'(triggered), 0);
    chk("coincide_warning", 32'(warning), 0);
    heartbeat = '0; n = -1;
    for (int k = 1; k <= 20 && n < 0; k++) begin
      cycle();
      if (triggered[0]) n = k;
    end
    chk("coincide_retrip_delay", n, 8);

    // Simultaneous trips, then staggered trips stretching the pulse.
    do_reset();
    enable = 2'b11;
    for (int i = 0; i < 9; i++) cycle();
    chk("dual_trip_count", 32'(trip_count), 2);
    repeat (6) cycle();
    clear = 2'b01; cycle();
    clear = 2'b00; cycle();
    clear = 2'b10; cycle();
    clear = 2'b00; fcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      fcnt += int'(force_reset);
    end
    chk("stagger_force_cycles", fcnt, 6);
    chk("stagger_trip_count", 32'(trip_count), 4);

    // Small timeout write is clamped to WARN_MARGIN+2.
    do_reset();
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_timeout = 16'd2;
    cycle();
    cfg_we = 1'b0;
    cycle();
    enable = 2'b10;
    cycle();
    n = -1;
    for (int k = 1; k <= 20 && n < 0; k++) begin
      cycle();
      if (triggered[1]) n = k;
    end
    chk("clamp_trip_delay", n, 5);

    // Async reset while one channel pulses in TRIP and the other is warning.
    do_reset();
    enable = 2'b01;
    repeat (3) cycle();
    enable = 2'b11;
    repeat (7) cycle();
    chk("pre_rst_warning", 32'(warning), 32'(2'b10));
    chk("pre_rst_force", 32'(force_reset), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_warning", 32'(warning), 0);
    chk("async_triggered", 32'(triggered), 0);
    chk("async_force", 32'(force_reset), 0);
    chk("async_count", 32'(trip_count), 0);
    model_reset();
    enable = '0;
    @(negedge clk);
    rst = 1'b0;
    enable = 2'b01;
    repeat (9) cycle();
    enable = 2'b00;
    cycle();
    chk("trip_ignores_enable", 32'(triggered), 32'(2'b01));
    clear = 2'b01;
    cycle();
    clear = 2'b00;
    repeat (10) cycle();
    chk("clear_to_idle_triggered", 32'(triggered), 0);
    chk("clear_to_idle_warning", 32'(warning), 0);

    // Randomized traffic against the reference.
    do_reset();
    enable = 2'b11;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 19) == 0) enable[c] = ~enable[c];
        heartbeat[c] = ($urandom_range(0, 9) == 0);
        clear[c] = ($urandom_range(0, 3) == 0);
      end
      cfg_we = ($urandom_range(0, 14) == 0);
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_timeout = 16'($urandom_range(0, 14));
      cycle();
    end
    cfg_we = 1'b0;

    // Held clear makes both channels trip every 9 cycles: saturate the counter.
    do_reset();
    enable = 2'b11; clear = 2'b11;
    for (int i = 0; i < 135 * 9; i++) cycle();
    chk("saturate_count", 32'(trip_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_watchdog.md
MULTI_WATCHDOG -- requirements
Module: multi_watchdog

Interface
REQ-001 Parameter N_CH, default 4, number of independent watchdog channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter and timeout width.
REQ-003 Parameter TIMEOUT_DEF, default 50_000_000, per-channel timeout loaded at reset.
REQ-004 Parameter WARN_MARGIN, default 10_000_000, cycles before timeout at which warning asserts.
REQ-005 Parameter RST_PULSE, default 16, force_reset pulse length in cycles (>=1).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-high.
REQ-008 enable  in  N_CH  per-channel arm, level.
REQ-009 heartbeat  in  N_CH  per-channel kick, level, sampled each clk.
REQ-010 clear  in  N_CH  per-channel acknowledge of a tripped channel.
REQ-011 cfg_we  in  1  timeout register write strobe.
REQ-012 cfg_ch  in  max(1,$clog2(N_CH))  channel select for write.
REQ-013 cfg_timeout  in  CNT_W  new timeout value.
REQ-014 warning  out  N_CH  channel in WARN state.
REQ-015 triggered  out  N_CH  channel in TRIP state, sticky.
REQ-016 force_reset  out  1  system reset request pulse.
REQ-017 trip_count  out  8  saturating count of trip events since reset.

Function
REQ-018 Each channel SHALL run an FSM with states IDLE, RUN, WARN, TRIP and its own CNT_W counter and timeout register.
REQ-019 IDLE: counter held 0; enable=1 -> RUN with counter 0.
REQ-020 RUN: counter +1 per cycle; heartbeat=1 -> counter 0; counter reaching timeout-WARN_MARGIN -> WARN.
REQ-021 WARN: counter +1; heartbeat=1 -> RUN, counter 0; counter reaching timeout-1 -> TRIP.
REQ-022 Timing: heartbeat last high in cycle t, no further heartbeat -> warning rises at edge t+timeout-WARN_MARGIN, triggered rises at edge t+timeout.
REQ-023 Heartbeat and terminal count in the same cycle: heartbeat wins, no trip.
REQ-024 enable=0 in RUN or WARN -> IDLE, counter 0; enable ignored in TRIP.
REQ-025 TRIP: counter frozen, heartbeat ignored; clear=1 -> RUN (counter 0) if enable=1, else IDLE.
REQ-026 warning and triggered SHALL be registered decodes of state; never both high.
REQ-027 cfg_we=1 writes cfg_timeout to channel cfg_ch; cfg_ch >= N_CH ignored.
REQ-028 Written values below WARN_MARGIN+2 SHALL be clamped to WARN_MARGIN+2.
REQ-029 New timeout SHALL take effect at the channel's next counter clear; the running count compares against the latched active value.
REQ-030 Any channel entering TRIP SHALL drive force_reset high for exactly RST_PULSE cycles from the next edge; a new trip during the pulse restarts the full length.
REQ-031 trip_count SHALL add the number of channels entering TRIP that cycle, saturating at 255.

Reset
REQ-032 rst SHALL asynchronously force all channels to IDLE, counters 0, timeout registers TIMEOUT_DEF, warning 0, triggered 0, force_reset 0, trip_count 0.
REQ-033 rst mid-pulse SHALL terminate force_reset immediately; rst in TRIP clears the trip.
REQ-034 After rst deasserts, channels with enable=1 enter RUN on the first clk edge.

Structure
REQ-035 FSM state enum and the clamp helper SHALL live in shared package wdg_pkg.
REQ-036 Per-channel logic SHALL be sub-module wdg_channel, generated N_CH times; the top holds config decode, pulse stretcher and trip counter.

Verification (N_CH=2, TIMEOUT_DEF=8, WARN_MARGIN=3, RST_PULSE=4)
REQ-037 Enable ch0, no heartbeat -> warning[0] high at edge 5, triggered[0] at edge 8, force_reset high 4 cycles, trip_count=1.
REQ-038 Heartbeat ch0 every 6 cycles -> warning pulses, never triggered, force_reset stays 0.
REQ-039 Heartbeat coincident with terminal count -> no trip; counter 0.
REQ-040 Both channels trip same cycle -> trip_count=2; ch1 trips 2 cycles after ch0 -> force_reset spans 6 cycles.
REQ-041 cfg write ch1 timeout=2 -> clamped to 5; trip after 5 cycles following next clear.
REQ-042 rst asserted mid-WARN and mid-pulse -> all outputs 0 asynchronously; clear in TRIP with enable=0 -> IDLE.
